// File: rtl/sort_engine_arbiter_pkg.sv
// sort_arb_pkg: shared types and helpers for the sort engine arbiter.
//   arb_state_t  - scheduler FSM states
//   tag_t        - one tag pipeline stage {valid, owner id}
//   clog2_min1   - $clog2 clamped to at least one bit
// The tag id is sized for the largest supported requester count (16), so one
// tag_t serves every legal NUM_REQ; narrower ids are zero-extended.
package sort_arb_pkg;

    typedef enum logic [1:0] {
        RUN,
        HOLD,
        DRAIN,
        IDLE
    } arb_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int MAX_REQ = 16;
    localparam int ID_W    = clog2_min1(MAX_REQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/sort_engine_arbiter_if.sv
// sort_engine_arbiter_if: requester and engine buses of the sort engine arbiter.
//   req_valid/req_seq/req_ready - per-requester vector handshake
//   res_valid/res_seq           - one-hot result strobe, broadcast result vector
//   eng_*                       - issue and return ports of the shared engine
// Modport slave is the arbiter; modport master is the surrounding system.
interface sort_engine_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 8,
    parameter int WIDTH   = 32
);
    localparam int SEQ_W = DEPTH * WIDTH;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0][SEQ_W-1:0] req_seq;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            res_valid;
    logic [SEQ_W-1:0]              res_seq;
    logic                          eng_valid_in;
    logic [SEQ_W-1:0]              eng_seq_in;
    logic                          eng_valid_out;
    logic [SEQ_W-1:0]              eng_seq_out;

    modport slave (
        input  req_valid, req_seq, eng_valid_out, eng_seq_out,
        output req_ready, res_valid, res_seq, eng_valid_in, eng_seq_in
    );

    modport master (
        output req_valid, req_seq, eng_valid_out, eng_seq_out,
        input  req_ready, res_valid, res_seq, eng_valid_in, eng_seq_in
    );
endinterface

// File: rtl/sort_engine_arbiter_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin grant.
//   req        in  N   request vector
//   ptr        in  PW  last granted index; search starts at ptr+1
//   grant      out N   one-hot grant or zero
//   grant_id   out PW  index of the granted requester (ptr when none)
//   grant_any  out 1   some requester was granted
//   next_ptr   out PW  pointer value to load if the grant is taken
module rr_arbiter
    import sort_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_id,
    output logic          grant_any,
    output logic [PW-1:0] next_ptr
);
    logic [PW-1:0] idx;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves a value unassigned and infers a latch.
    always_comb begin
        grant     = '0;
        grant_id  = ptr;
        grant_any = 1'b0;
        idx       = '0;
        // Walk ptr+1, ptr+2, ... wrapping; the first requester found wins.
        for (int i = 1; i <= N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
        next_ptr = grant_any ? grant_id : ptr;
    end
endmodule

// File: rtl/sort_engine_arbiter.sv
// sort_engine_arbiter: round-robin scheduler sharing one pipelined sort engine
// among NUM_REQ requesters, with a tag pipeline that routes each result home.
//   clk, rst     - clock; asynchronous active-high reset
//   bus (slave)  - requester handshakes, result strobe, engine issue/return
//   pause        - stop issuing while high; in-flight work completes
//   drain        - pulse: stop issuing until empty, then go IDLE
//   busy         - some vector is in flight
//   tag_err      - sticky: engine valid_out disagreed with the tag pipeline
//   job_count    - per-requester saturating issue counters (only with
//                  SORT_ARB_STATS_EN defined)
module sort_engine_arbiter
    import sort_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DEPTH      = 8,
    parameter int WIDTH      = 32,
    parameter int ENGINE_LAT = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    sort_engine_arbiter_if.slave bus,
    input  logic                 pause,
    input  logic                 drain,
    output logic                 busy,
    output logic                 tag_err
`ifdef SORT_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][15:0] job_count
`endif
);
    localparam int REQ_ID_W = clog2_min1(NUM_REQ);
    localparam int CNT_W    = $clog2(ENGINE_LAT + 1);
    localparam int SEQ_W    = DEPTH * WIDTH;

    arb_state_t state_q, state_d;

    logic [REQ_ID_W-1:0] rr_ptr_q, rr_ptr_d, grant_id, next_ptr;
    logic [NUM_REQ-1:0]  grant, req_ready;
    logic                grant_any, handshake;

    logic                eng_valid_in_q, eng_valid_in_d;
    logic [SEQ_W-1:0]    eng_seq_in_q, eng_seq_in_d;
    logic [REQ_ID_W-1:0] issue_id_q, issue_id_d;
    tag_t                tag_q [ENGINE_LAT];
    tag_t                tag_d [ENGINE_LAT];
    tag_t                tail;
    logic                deliver;
    logic [NUM_REQ-1:0]  res_valid_q, res_valid_d;
    logic [SEQ_W-1:0]    res_seq_q, res_seq_d;
    logic                tag_err_q, tag_err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    rr_arbiter #(.N(NUM_REQ), .PW(REQ_ID_W)) u_rr (
        .req       (bus.req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any),
        .next_ptr  (next_ptr)
    );

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:   if (drain) state_d = DRAIN; else if (pause)  state_d = HOLD;
            HOLD:  if (drain) state_d = DRAIN; else if (!pause) state_d = RUN;
            // The vector in the issue register is not yet counted, so wait for it too.
            DRAIN: if (cnt_q == '0 && !eng_valid_in_q) state_d = IDLE;
            IDLE:  if (!pause && !drain) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Grants are masked while rst is high so no requester believes a vector was
    // taken while the issue flops are held in reset.
    always_comb begin
        req_ready = (state_q == RUN && grant_any && !rst) ? grant : '0;
        handshake = |(bus.req_valid & req_ready);
    end

    // ---------------- Datapath next-state ----------------
    assign tail    = tag_q[ENGINE_LAT-1];
    assign deliver = bus.eng_valid_out && tail.valid;

    always_comb begin
        rr_ptr_d       = handshake ? next_ptr : rr_ptr_q;
        eng_valid_in_d = handshake;
        eng_seq_in_d   = handshake ? bus.req_seq[grant_id] : eng_seq_in_q;
        issue_id_d     = handshake ? grant_id : issue_id_q;

        // Tags enter as the vector is sampled by the engine, so the tail lines
        // up with engine valid_out ENGINE_LAT cycles later.
        tag_d[0] = '{valid: eng_valid_in_q, id: ID_W'(issue_id_q)};
        for (int i = 1; i < ENGINE_LAT; i++) tag_d[i] = tag_q[i-1];

        res_valid_d = deliver ? (NUM_REQ'(1) << tail.id) : '0;
        res_seq_d   = deliver ? bus.eng_seq_out : res_seq_q;
        tag_err_d   = tag_err_q | (bus.eng_valid_out != tail.valid);

        // Retire follows the tag pipeline even when the engine dropped the
        // result, so a lost valid_out cannot leave the counter stuck.
        unique case ({eng_valid_in_q, tail.valid})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: every flop here is reset, including the vector registers: stale tag
    // valids would misroute results, and the data outputs must read zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q       <= REQ_ID_W'(NUM_REQ - 1);
            eng_valid_in_q <= 1'b0;
            eng_seq_in_q   <= '0;
            issue_id_q     <= '0;
            for (int i = 0; i < ENGINE_LAT; i++) tag_q[i] <= '0;
            res_valid_q    <= '0;
            res_seq_q      <= '0;
            tag_err_q      <= 1'b0;
            cnt_q          <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            eng_valid_in_q <= eng_valid_in_d;
            eng_seq_in_q   <= eng_seq_in_d;
            issue_id_q     <= issue_id_d;
            for (int i = 0; i < ENGINE_LAT; i++) tag_q[i] <= tag_d[i];
            res_valid_q    <= res_valid_d;
            res_seq_q      <= res_seq_d;
            tag_err_q      <= tag_err_d;
            cnt_q          <= cnt_d;
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.eng_valid_in = eng_valid_in_q;
    assign bus.eng_seq_in   = eng_seq_in_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_seq      = res_seq_q;
    assign busy             = (cnt_q != '0);
    assign tag_err          = tag_err_q;

`ifdef SORT_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] job_cnt_q, job_cnt_d;

    always_comb begin
        job_cnt_d = job_cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && bus.req_valid[i] && job_cnt_q[i] != 16'hFFFF)
                job_cnt_d[i] = job_cnt_q[i] + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) job_cnt_q <= '0;
        else     job_cnt_q <= job_cnt_d;
    end

    assign job_count = job_cnt_q;
`endif
endmodule
